// File: rtl/uart_pkg.sv
// Shared constants, state encoding and divider helper for the UART word scheduler.
package uart_pkg;

  localparam int FRAME_BITS     = 10;  // start + 8 data + stop
  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;
  localparam int WORD_W         = BYTES_PER_WORD * DATA_BITS;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Clock cycles per serial bit (integer division).
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 transmitter: baud counter plus 10-bit frame shifter.
// A load in the last STOP cycle chains the next byte with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] byte_in,
  output logic                 busy,
  output logic                 byte_done,
  output logic                 tx
);

  localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
  localparam int                 BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_BITS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        baud_q, baud_d;
  logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    bit_end;

  assign bit_end = (baud_q == CNT_LAST);

  // Next-state logic: advance one frame bit every DIV cycles.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    byte_done = 1'b0;

    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (load) begin
          frame_d = {1'b1, byte_in, 1'b0};
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          byte_done = 1'b1;
          if (load) begin
            frame_d = {1'b1, byte_in, 1'b0};
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign tx   = (state_q == IDLE) ? 1'b1 : frame_q[0];

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART tx line between NREQ word producers.
// Each granted 32-bit word goes out as 4 back-to-back 8N1 bytes, LSB byte first.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 9600,
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic                   tx
);

  localparam int                DIV       = calc_div(CLK_HZ, BAUD);
  localparam int                PW        = $clog2(NREQ);
  localparam int                BIDX_W    = $clog2(BYTES_PER_WORD);
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(BYTES_PER_WORD - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_sched: CLK_HZ/BAUD must be at least 2");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("uart_tx_sched: NREQ must be in 2..8");
  end

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW:0]       cand;
  logic [PW:0]       nxt;
  logic              load;
  logic [DATA_BITS-1:0] byte_in;
  logic              byte_busy;
  logic              byte_done;

  logic [WORD_W-1:0] words [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = data[i*WORD_W +: WORD_W];
  end

  // Arbiter: first requester with req high, scanning upward from ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    nxt = {1'b0, win} + 1'b1;
  end

  // Word sequencing: grant from idle, chain bytes, pulse done after the last stop bit.
  always_comb begin
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    gnt_d      = '0;
    done_d     = '0;
    load       = 1'b0;
    byte_in    = word_q[2*DATA_BITS-1:DATA_BITS];

    if (!busy_q && !byte_busy) begin
      if (found) begin
        load       = 1'b1;
        byte_in    = words[win][DATA_BITS-1:0];
        word_d     = words[win];
        gnt_d[win] = 1'b1;
        busy_d     = 1'b1;
        ptr_d      = (nxt == (PW+1)'(NREQ)) ? '0 : nxt[PW-1:0];
        byte_idx_d = '0;
        owner_d    = win;
      end
    end else if (byte_done) begin
      if (byte_idx_q != BYTE_LAST) begin
        load       = 1'b1;
        byte_idx_d = byte_idx_q + 1'b1;
        word_d     = word_q >> DATA_BITS;
      end else begin
        busy_d          = 1'b0;
        done_d[owner_q] = 1'b1;
      end
    end
  end

  // Scheduler registers; a reset mid-word drops the word and forgets the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
    end
  end

  uart_byte_tx #(
    .DIV(DIV)
  ) u_byte_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .byte_in  (byte_in),
    .busy     (byte_busy),
    .byte_done(byte_done),
    .tx       (tx)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
